// File: rtl/frame_capture_pkg.sv
// Shared types and limits for the OV7670 frame capture write scheduler.
package frame_capture_pkg;

   typedef enum logic [2:0] {
      ST_SYNC   = 3'd0,
      ST_LIVE   = 3'd1,
      ST_ARMED  = 3'd2,
      ST_SNAP   = 3'd3,
      ST_FROZEN = 3'd4
   } cap_state_t;

   localparam int FRAME_DIV_MIN = 1;
   localparam int FRAME_DIV_MAX = 16;

   // Out-of-range decimation settings are pulled back into the legal window.
   function automatic int clamp_div(input int d);
      if (d < FRAME_DIV_MIN) return FRAME_DIV_MIN;
      if (d > FRAME_DIV_MAX) return FRAME_DIV_MAX;
      return d;
   endfunction

   function automatic int div_cnt_width(input int d);
      return (d <= 2) ? 1 : $clog2(d);
   endfunction

endpackage

// File: rtl/vsync_edge_detect.sv
// Registers raw camera vsync and flags the frame boundaries in the cycle vsync moves.
module vsync_edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic vsync,
   output logic frame_start,
   output logic frame_end
);

   logic vs_q;

   // vs_q resets high: a low vsync at reset release reads as frame_start, which SYNC ignores.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) vs_q <= 1'b1;
      else       vs_q <= vsync;
   end

   assign frame_start = vs_q & ~vsync;
   assign frame_end   = ~vs_q & vsync;

endmodule

// File: rtl/frame_capture_ctrl.sv
// Frame-level write gate for the frame buffer: whole frames only, with live,
// decimated, freeze and snapshot modes plus frame-aligned resolution switching.
module frame_capture_ctrl
   import frame_capture_pkg::*;
#(
   parameter int FRAME_DIV = 1,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             vsync,
   input  logic             we_in,
   input  logic             freeze,
   input  logic             snap_req,
   input  logic             rez_160x120_req,
   input  logic             rez_320x240_req,
   output logic             we_out,
   output logic             rez_160x120,
   output logic             rez_320x240,
   output logic             snap_done,
   output logic             capture_active,
   output logic [CNT_W-1:0] frame_count
);

   localparam int               DIV_EFF  = clamp_div(FRAME_DIV);
   localparam int               DIV_W    = div_cnt_width(DIV_EFF);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_EFF - 1);

   cap_state_t       state, state_nxt;
   logic             capture_nxt;
   logic             frame_start, frame_end;
   logic [DIV_W-1:0] div_cnt;

   vsync_edge_detect u_edge (
      .clk         (clk),
      .reset       (reset),
      .vsync       (vsync),
      .frame_start (frame_start),
      .frame_end   (frame_end)
   );

   // NOTE: every output of this block gets a default first, so no path infers a latch.
   always_comb begin
      state_nxt   = state;
      capture_nxt = capture_active;

      case (state)
         ST_SYNC: begin
            if (frame_end) state_nxt = freeze ? ST_FROZEN : ST_LIVE;
         end
         ST_LIVE: begin
            if (snap_req)                state_nxt = frame_start ? ST_SNAP : ST_ARMED;
            else if (freeze && frame_end) state_nxt = ST_FROZEN;
         end
         ST_FROZEN: begin
            if (snap_req)     state_nxt = frame_start ? ST_SNAP : ST_ARMED;
            else if (!freeze) state_nxt = ST_LIVE;
         end
         ST_ARMED: begin
            if (frame_start) state_nxt = ST_SNAP;
         end
         ST_SNAP: begin
            if (frame_end) state_nxt = ST_FROZEN;
         end
         default: state_nxt = ST_SYNC;
      endcase

      // The gate only moves on a frame boundary, so a frame is written whole or not at all.
      if (frame_end)
         capture_nxt = 1'b0;
      else if (frame_start && (state_nxt == ST_SNAP || (state == ST_LIVE && div_cnt == '0)))
         capture_nxt = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= ST_SYNC;
         capture_active <= 1'b0;
         snap_done      <= 1'b0;
         rez_160x120    <= 1'b0;
         rez_320x240    <= 1'b0;
      end else begin
         state          <= state_nxt;
         capture_active <= capture_nxt;
         snap_done      <= (state == ST_SNAP) && frame_end;
         if (frame_start) begin
            rez_160x120 <= rez_160x120_req;
            rez_320x240 <= rez_320x240_req & ~rez_160x120_req;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt     <= '0;
         frame_count <= '0;
      end else begin
         if (frame_end && capture_active)
            frame_count <= frame_count + CNT_W'(1);

         if (state != ST_LIVE && state_nxt == ST_LIVE)
            div_cnt <= '0;
         else if (state == ST_LIVE && frame_start)
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
      end
   end

   // Combinational so capture address and data stay aligned with the enable.
   assign we_out = we_in & capture_active;

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Self-checking bench: two instances (FRAME_DIV 1 and 3) against a frame-level reference model.
module tb_frame_capture_ctrl;

   logic       clk = 1'b0;
   logic       reset, vsync, we_in, freeze, snap_req, rez_160x120_req, rez_320x240_req;
   logic [1:0] we_out, rez_160x120, rez_320x240, snap_done, capture_active;
   logic [7:0] frame_count [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   frame_capture_ctrl #(.FRAME_DIV(1), .CNT_W(8)) dut1 (
      .clk(clk), .reset(reset), .vsync(vsync), .we_in(we_in), .freeze(freeze),
      .snap_req(snap_req), .rez_160x120_req(rez_160x120_req), .rez_320x240_req(rez_320x240_req),
      .we_out(we_out[0]), .rez_160x120(rez_160x120[0]), .rez_320x240(rez_320x240[0]),
      .snap_done(snap_done[0]), .capture_active(capture_active[0]), .frame_count(frame_count[0])
   );

   frame_capture_ctrl #(.FRAME_DIV(3), .CNT_W(8)) dut3 (
      .clk(clk), .reset(reset), .vsync(vsync), .we_in(we_in), .freeze(freeze),
      .snap_req(snap_req), .rez_160x120_req(rez_160x120_req), .rez_320x240_req(rez_320x240_req),
      .we_out(we_out[1]), .rez_160x120(rez_160x120[1]), .rez_320x240(rez_320x240[1]),
      .snap_done(snap_done[1]), .capture_active(capture_active[1]), .frame_count(frame_count[1])
   );

   // ---------------- reference model ----------------
   typedef enum {M_SYNC, M_LIVE, M_ARMED, M_SNAP, M_FROZEN} mode_t;
   mode_t m_mode  [2];
   bit    m_gate  [2], m_vs_prev [2], m_sd [2], m_r160 [2], m_r320 [2];
   int    m_count [2], m_live_frames [2];
   int    div_of  [2] = '{1, 3};

   task automatic model_reset(input int k);
      m_mode[k] = M_SYNC; m_gate[k] = 0; m_vs_prev[k] = 1; m_sd[k] = 0;
      m_r160[k] = 0; m_r320[k] = 0; m_count[k] = 0; m_live_frames[k] = 0;
   endtask

   task automatic model_step(input int k);
      bit fs, fe;
      mode_t nm;
      if (reset) begin
         model_reset(k);
         return;
      end
      fs = m_vs_prev[k] && !vsync;
      fe = !m_vs_prev[k] && vsync;
      nm = m_mode[k];
      case (m_mode[k])
         M_SYNC:   if (fe) nm = freeze ? M_FROZEN : M_LIVE;
         M_LIVE:   if (snap_req) nm = fs ? M_SNAP : M_ARMED; else if (freeze && fe) nm = M_FROZEN;
         M_FROZEN: if (snap_req) nm = fs ? M_SNAP : M_ARMED; else if (!freeze) nm = M_LIVE;
         M_ARMED:  if (fs) nm = M_SNAP;
         M_SNAP:   if (fe) nm = M_FROZEN;
      endcase
      m_sd[k] = (m_mode[k] == M_SNAP) && fe;
      if (fe && m_gate[k]) m_count[k] = (m_count[k] + 1) % 256;
      if (fe) m_gate[k] = 0;
      else if (fs && (nm == M_SNAP || (m_mode[k] == M_LIVE && (m_live_frames[k] % div_of[k]) == 0)))
         m_gate[k] = 1;
      if (m_mode[k] == M_LIVE && fs) m_live_frames[k]++;
      if (m_mode[k] != M_LIVE && nm == M_LIVE) m_live_frames[k] = 0;
      if (fs) begin
         m_r160[k] = rez_160x120_req;
         m_r320[k] = rez_320x240_req && !rez_160x120_req;
      end
      m_vs_prev[k] = vsync;
      m_mode[k]    = nm;
   endtask

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   bit cur_fz = 0, cur_r160 = 0, cur_r320 = 0;
   bit obs_we [2], obs_sd [2], obs_r160 [2], obs_r320 [2];
   int obs_fc [2];

   // One clock: drive at posedge+1, compare at negedge, advance the model at posedge.
   task automatic tick(input bit vs, input bit we, input bit sn, input bit rst);
      vsync = vs; we_in = we; snap_req = sn; reset = rst;
      freeze = cur_fz; rez_160x120_req = cur_r160; rez_320x240_req = cur_r320;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         check($sformatf("we_out[%0d]", k),         32'(we_out[k]),         32'(we & m_gate[k]));
         check($sformatf("capture_active[%0d]", k), 32'(capture_active[k]), 32'(m_gate[k]));
         check($sformatf("frame_count[%0d]", k),    32'(frame_count[k]),    32'(m_count[k]));
         check($sformatf("snap_done[%0d]", k),      32'(snap_done[k]),      32'(m_sd[k]));
         check($sformatf("rez_160x120[%0d]", k),    32'(rez_160x120[k]),    32'(m_r160[k]));
         check($sformatf("rez_320x240[%0d]", k),    32'(rez_320x240[k]),    32'(m_r320[k]));
         obs_we[k] = we_out[k]; obs_sd[k] = snap_done[k]; obs_fc[k] = int'(frame_count[k]);
         obs_r160[k] = rez_160x120[k]; obs_r320[k] = rez_320x240[k];
      end
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
   endtask

   // Two blanking cycles then four active cycles with we_in high; counts we_out cycles per DUT.
   task automatic frame(input int snap_at, input int fz_at, input bit fz_new, output int w0, output int w1);
      w0 = 0; w1 = 0;
      repeat (2) tick(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         if (i == fz_at) cur_fz = fz_new;
         tick(1'b0, 1'b1, i == snap_at, 1'b0);
         w0 += int'(obs_we[0]);
         w1 += int'(obs_we[1]);
      end
   endtask

   // ---------------- directed vectors (FRAME_DIV = 1 instance) ----------------
   typedef struct {
      bit vs, we, r160_req, r320_req;
      bit e_we;
      int e_fc;
      bit e_r160, e_r320;
   } vec_t;

   function automatic vec_t mk(bit vs, bit we, bit a, bit b, bit ew, int efc, bit e1, bit e2);
      vec_t v;
      v.vs = vs; v.we = we; v.r160_req = a; v.r320_req = b;
      v.e_we = ew; v.e_fc = efc; v.e_r160 = e1; v.e_r320 = e2;
      return v;
   endfunction

   vec_t vecs [17];
   int   w0, w1, fc_before, bl, al, rst_at, sn_at, fz_at;

   initial begin
      // Sync frame, then two written frames; rez requests switch only at frame starts.
      vecs[0]  = mk(1,1,0,0, 0,0,0,0);
      vecs[1]  = mk(0,1,0,1, 0,0,0,0);
      vecs[2]  = mk(0,1,0,1, 0,0,0,1);
      vecs[3]  = mk(0,1,0,1, 0,0,0,1);
      vecs[4]  = mk(1,1,0,1, 0,0,0,1);
      vecs[5]  = mk(1,1,0,0, 0,0,0,1);
      vecs[6]  = mk(0,1,0,0, 0,0,0,1);
      vecs[7]  = mk(0,1,0,0, 1,0,0,0);
      vecs[8]  = mk(0,0,0,0, 0,0,0,0);
      vecs[9]  = mk(0,1,0,0, 1,0,0,0);
      vecs[10] = mk(1,1,0,0, 1,0,0,0);
      vecs[11] = mk(1,1,0,0, 0,1,0,0);
      vecs[12] = mk(0,1,1,1, 0,1,0,0);
      vecs[13] = mk(0,1,1,1, 1,1,1,0);
      vecs[14] = mk(0,0,1,1, 0,1,1,0);
      vecs[15] = mk(1,0,1,1, 0,1,1,0);
      vecs[16] = mk(1,1,1,1, 0,2,1,0);

      reset = 1; vsync = 1; we_in = 0; freeze = 0; snap_req = 0;
      rez_160x120_req = 0; rez_320x240_req = 0;
      repeat (2) @(posedge clk);
      #1;
      model_reset(0);
      model_reset(1);

      for (int i = 0; i < 17; i++) begin
         cur_r160 = vecs[i].r160_req;
         cur_r320 = vecs[i].r320_req;
         tick(vecs[i].vs, vecs[i].we, 1'b0, 1'b0);
         check($sformatf("vec%0d.we_out", i),      32'(obs_we[0]),   32'(vecs[i].e_we));
         check($sformatf("vec%0d.frame_count", i), 32'(obs_fc[0]),   32'(vecs[i].e_fc));
         check($sformatf("vec%0d.rez_160", i),     32'(obs_r160[0]), 32'(vecs[i].e_r160));
         check($sformatf("vec%0d.rez_320", i),     32'(obs_r320[0]), 32'(vecs[i].e_r320));
         check($sformatf("vec%0d.snap_done", i),   32'(obs_sd[0]),   32'(0));
      end
      cur_r160 = 0; cur_r320 = 0;

      // Decimation: after reset, one sync frame then seven live frames.
      repeat (2) tick(1'b1, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 8; k++) begin
         frame(-1, -1, 1'b0, w0, w1);
         check($sformatf("div1.frame%0d", k), 32'(w0), 32'((k >= 1) ? 3 : 0));
         check($sformatf("div3.frame%0d", k), 32'(w1), 32'((k % 3 == 1) ? 3 : 0));
      end
      repeat (2) tick(1'b1, 1'b0, 1'b0, 1'b0);
      check("div3.frame_count", 32'(obs_fc[1]), 32'(3));
      check("div1.frame_count", 32'(obs_fc[0]), 32'(7));

      // Freeze raised mid-frame: that frame completes, later frames are held.
      fc_before = obs_fc[0];
      frame(-1, 2, 1'b1, w0, w1);
      check("freeze.inflight_frame", 32'(w0), 32'(3));
      frame(-1, -1, 1'b1, w0, w1);
      check("freeze.held_frame1", 32'(w0), 32'(0));
      frame(-1, -1, 1'b1, w0, w1);
      check("freeze.held_frame2", 32'(w0), 32'(0));
      check("freeze.frame_count", 32'(obs_fc[0]), 32'(fc_before + 1));

      // Snapshot from FROZEN: request mid-frame, next frame written, second request ignored.
      fc_before = obs_fc[0];
      frame(1, -1, 1'b1, w0, w1);
      check("snap.rest_of_req_frame", 32'(w0), 32'(0));
      frame(2, -1, 1'b1, w0, w1);
      check("snap.snap_frame", 32'(w0), 32'(3));
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      check("snap.done_at_rise", 32'(obs_sd[0]), 32'(0));
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      check("snap.done_next", 32'(obs_sd[0]), 32'(1));
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      check("snap.done_width", 32'(obs_sd[0]), 32'(0));
      frame(-1, -1, 1'b1, w0, w1);
      check("snap.hold_after", 32'(w0), 32'(0));
      check("snap.frame_count", 32'(obs_fc[0]), 32'(fc_before + 1));

      // Resolution request toggled mid-frame switches only after the next frame start.
      cur_fz = 0;
      repeat (2) tick(1'b1, 1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      cur_r320 = 1;
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      check("rez.hold_midframe", 32'(obs_r320[0]), 32'(0));
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      check("rez.hold_blank", 32'(obs_r320[0]), 32'(0));
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      check("rez.hold_at_fall", 32'(obs_r320[0]), 32'(0));
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      check("rez.switch_after_fall", 32'(obs_r320[0]), 32'(1));
      cur_r160 = 1;
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      frame(-1, -1, 1'b0, w0, w1);
      check("rez.both_160", 32'(obs_r160[0]), 32'(1));
      check("rez.both_320", 32'(obs_r320[0]), 32'(0));

      // Reset halfway through a written frame.
      repeat (2) tick(1'b1, 1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      check("rst.writing_before", 32'(obs_we[0]), 32'(1));
      tick(1'b0, 1'b1, 1'b0, 1'b1);
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      check("rst.gate_closed", 32'(obs_we[0]), 32'(0));
      check("rst.count_cleared", 32'(obs_fc[0]), 32'(0));
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      frame(-1, -1, 1'b0, w0, w1);
      check("rst.resume_frame", 32'(w0), 32'(3));
      check("rst.partial_not_counted", 32'(obs_fc[0]), 32'(0));
      repeat (2) tick(1'b1, 1'b0, 1'b0, 1'b0);
      check("rst.count_after_resume", 32'(obs_fc[0]), 32'(1));

      // Randomized frames with freeze toggles, snapshot pulses and occasional resets.
      for (int f = 0; f < 300; f++) begin
         bl     = $urandom_range(1, 4);
         al     = $urandom_range(1, 8);
         rst_at = ($urandom_range(0, 39) == 0) ? bl + $urandom_range(0, al - 1) : -1;
         sn_at  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, bl + al - 1) : -1;
         fz_at  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, bl + al - 1) : -1;
         if ($urandom_range(0, 3) == 0) begin
            cur_r160 = 1'($urandom_range(0, 1));
            cur_r320 = 1'($urandom_range(0, 1));
         end
         for (int c = 0; c < bl + al; c++) begin
            if (c == fz_at) cur_fz = !cur_fz;
            tick(c < bl, 1'($urandom_range(0, 1)), c == sn_at, c == rst_at);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
